cnn_img_fetch: RTL and testbench
================================

CNN_IMG_FETCH -- requirements
Module: cnn_img_fetch

Interface
REQ-001 SHALL have parameter FIFO_DEPTH, 4, output buffer depth in 32-bit words (power of 2, >=2).
REQ-002 SHALL have parameter W_CNT, 16, width of the word-count field.
REQ-003 SHALL have port HCLK  input  1  clock; all logic on rising edge.
REQ-004 SHALL have port HRESET  input  1  reset; one clock, synchronous and active-high.
REQ-005 SHALL have port i_start  input  1  one-cycle pulse; begin a fetch.
REQ-006 SHALL have port i_base_addr  input  32  byte address of the first word; bits [1:0] are ignored.
REQ-007 SHALL have port i_word_cnt  input  W_CNT  number of words to fetch.
REQ-008 SHALL have ports HADDR output 32, HTRANS output 2, HBURST output 3, HSIZE output 3, HWRITE output 1 and HWDATA output 32, forming the AHB-Lite master address/control bus.
REQ-009 SHALL have ports HREADY input 1, HRESP input 2 and HRDATA input 32, forming the AHB-Lite master response bus.
REQ-010 SHALL have ports o_pix_valid output 1, o_pix_data output 32 and i_pix_ready input 1, forming the word stream to the CNN core.
REQ-011 SHALL have ports o_busy output 1, o_done output 1 (one-cycle pulse) and o_err output 1 (sticky until next accepted start).

Function
REQ-012 SHALL be read-only: HWRITE=0, HWDATA=0, HBURST=SINGLE (3'b000), HSIZE=WORD (3'b010) at all times.
REQ-013 SHALL use FSM states IDLE, RUN, DRAIN, DONE.
REQ-014 IDLE: i_start latches address ({i_base_addr[31:2],2'b00}), count and clears o_err; go to RUN if count>0, else DONE.
REQ-015 i_start outside IDLE SHALL be ignored.
REQ-016 RUN: drive HTRANS=NONSEQ (2'b10) with HADDR=current address when remaining>0 and (fifo_count + outstanding + 1) <= FIFO_DEPTH; otherwise HTRANS=IDLE (2'b00).
REQ-017 While HREADY=0, HADDR and HTRANS SHALL be held unchanged.
REQ-018 An address phase completes on a cycle with HREADY=1; on completion the address increments by 4 (modulo 2^32) and remaining decrements.
REQ-019 Data phase: HRDATA SHALL be written into the FIFO on the cycle HREADY=1 with HRESP=OKAY; at most one data phase outstanding.
REQ-020 Back-to-back pipelining SHALL apply: with a zero-wait slave and a non-full FIFO, one word per cycle.
REQ-021 RUN->DRAIN when the last address phase completes; DRAIN->DONE when its data phase completes.
REQ-022 DONE: o_done=1 for exactly one cycle; next state IDLE. o_busy=1 in RUN and DRAIN only.
REQ-023 Latency: i_start at cycle 0 -> NONSEQ at cycle 1 -> first word captured at end of cycle 2 -> o_pix_valid=1 at cycle 3 (zero-wait slave).
REQ-024 Stream: o_pix_data = FIFO head; a word pops when o_pix_valid & i_pix_ready. Simultaneous push and pop at full or empty SHALL be legal and keep count consistent.
REQ-025 FIFO SHALL never overflow; reads are throttled by REQ-016 only.
REQ-026 HRESP=ERROR (first cycle, HREADY=0): drive HTRANS=IDLE next cycle, discard the data, set o_err, go to DONE after the second error cycle.
REQ-027 Words already in the FIFO at error time SHALL remain drainable.
REQ-028 A count of 0 SHALL produce o_done at cycle 1 with no bus transfer.

Reset
REQ-029 On HRESET=1: FSM=IDLE, FIFO empty, HTRANS=2'b00, HADDR=0, o_pix_valid=0, o_pix_data=0, o_busy=0, o_done=0, o_err=0.
REQ-030 Reset mid-transfer SHALL abort: no further NONSEQ, and any in-flight data is discarded.

Verification
REQ-031 Base 0x0000_1000, count 8, zero-wait slave, ready=1 -> HADDR 0x1000..0x101C on consecutive cycles, 8 words out in order, o_done once, o_err=0.
REQ-032 Same fetch with i_pix_ready=0 -> exactly FIFO_DEPTH=4 NONSEQ issued, then HTRANS=IDLE; ready=1 -> remaining 4 fetched; no loss or duplication.
REQ-033 Slave inserts 2 wait states on word 3 -> HADDR/HTRANS held stable during the wait, data order intact.
REQ-034 ERROR response on word 5 of 8 -> o_err=1, o_done pulse, 4 words delivered, no NONSEQ after the error.
REQ-035 Count 0 -> o_done at cycle 1, HTRANS stays 2'b00; i_start while busy -> ignored.
REQ-036 Base 0xFFFF_FFF8, count 3 -> addresses 0xFFFF_FFF8, 0xFFFF_FFFC, 0x0000_0000; HRESET asserted mid-run -> all outputs at reset values next cycle.

Source files
------------

// File: rtl/cnn_img_fetch.sv
// cnn_img_fetch: AHB-Lite read-only master that fetches a block of 32-bit
// words and streams them to the CNN core through a small output FIFO.
// Reads are issued only when the FIFO is guaranteed to have room for them.
module cnn_img_fetch #(
    parameter int FIFO_DEPTH = 4,
    parameter int W_CNT      = 16
) (
    input  logic             HCLK,
    input  logic             HRESET,
    input  logic             i_start,
    input  logic [31:0]      i_base_addr,
    input  logic [W_CNT-1:0] i_word_cnt,
    output logic [31:0]      HADDR,
    output logic [1:0]       HTRANS,
    output logic [2:0]       HBURST,
    output logic [2:0]       HSIZE,
    output logic             HWRITE,
    output logic [31:0]      HWDATA,
    input  logic             HREADY,
    input  logic [1:0]       HRESP,
    input  logic [31:0]      HRDATA,
    output logic             o_pix_valid,
    output logic [31:0]      o_pix_data,
    input  logic             i_pix_ready,
    output logic             o_busy,
    output logic             o_done,
    output logic             o_err
);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int RW = PW + 2;
    localparam logic [1:0] TR_IDLE   = 2'b00;
    localparam logic [1:0] TR_NONSEQ = 2'b10;
    localparam logic [1:0] RESP_OKAY = 2'b00;

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

    state_t           state;
    logic [W_CNT-1:0] remaining;
    logic             dphase;

    logic [31:0]      mem [FIFO_DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic [PW:0]      fifo_cnt;
    logic [PW:0]      fifo_cnt_next;

    logic             addr_done;
    logic             data_done;
    logic             resp_err;
    logic             push;
    logic             pop;
    logic             dphase_next;
    logic [W_CNT-1:0] rem_next;
    logic [RW-1:0]    reserved;
    logic             credit_ok;
    logic             issue;
    logic             unused_addr_lsb;

    assign HBURST = 3'b000;
    assign HSIZE  = 3'b010;
    assign HWRITE = 1'b0;
    assign HWDATA = 32'h0;

    assign o_pix_valid     = (fifo_cnt != '0);
    assign o_pix_data      = o_pix_valid ? mem[rd_ptr] : 32'h0;
    assign unused_addr_lsb = ^i_base_addr[1:0];

    // Bus phase bookkeeping and the credit check: words in the FIFO, the word
    // in its data phase and the next request must all fit after this edge.
    always_comb begin
        addr_done     = (HTRANS == TR_NONSEQ) && HREADY;
        data_done     = dphase && HREADY;
        resp_err      = dphase && (HRESP != RESP_OKAY);
        push          = data_done && !resp_err;
        pop           = o_pix_valid && i_pix_ready;
        fifo_cnt_next = fifo_cnt;
        if (push && !pop) begin
            fifo_cnt_next = fifo_cnt + 1'b1;
        end else if (!push && pop) begin
            fifo_cnt_next = fifo_cnt - 1'b1;
        end
        dphase_next = HREADY ? addr_done : dphase;
        rem_next    = remaining - W_CNT'(addr_done);
        reserved    = RW'(fifo_cnt_next) + RW'(dphase_next) + RW'(1);
        credit_ok   = (reserved <= RW'(FIFO_DEPTH));
        issue       = (rem_next != '0) && credit_ok && !resp_err;
    end

    // Control FSM; owns the address phase outputs and the status flags.
    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            state     <= IDLE;
            HTRANS    <= TR_IDLE;
            HADDR     <= 32'h0;
            remaining <= '0;
            dphase    <= 1'b0;
            o_busy    <= 1'b0;
            o_done    <= 1'b0;
            o_err     <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    o_done <= 1'b0;
                    if (i_start) begin
                        HADDR     <= {i_base_addr[31:2], 2'b00};
                        remaining <= i_word_cnt;
                        o_err     <= 1'b0;
                        if (i_word_cnt != '0) begin
                            state  <= RUN;
                            o_busy <= 1'b1;
                            HTRANS <= credit_ok ? TR_NONSEQ : TR_IDLE;
                        end else begin
                            state  <= DONE;
                            o_done <= 1'b1;
                        end
                    end
                end
                RUN, DRAIN: begin
                    if (resp_err && !HREADY) begin
                        // First error cycle: cancel any pending request.
                        HTRANS <= TR_IDLE;
                        o_err  <= 1'b1;
                    end else if (resp_err) begin
                        // Second error cycle: drop the word and finish.
                        HTRANS <= TR_IDLE;
                        dphase <= 1'b0;
                        state  <= DONE;
                        o_busy <= 1'b0;
                        o_done <= 1'b1;
                    end else if (HREADY) begin
                        dphase <= addr_done;
                        HTRANS <= issue ? TR_NONSEQ : TR_IDLE;
                        if (addr_done) begin
                            HADDR     <= HADDR + 32'd4;
                            remaining <= rem_next;
                        end
                        if (state == RUN && addr_done && remaining == W_CNT'(1)) begin
                            state <= DRAIN;
                        end
                        if (state == DRAIN && data_done) begin
                            state  <= DONE;
                            o_busy <= 1'b0;
                            o_done <= 1'b1;
                        end
                    end
                end
                DONE: begin
                    state  <= IDLE;
                    o_done <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // FIFO pointers and occupancy.
    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            fifo_cnt <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            fifo_cnt <= fifo_cnt_next;
        end
    end

    // FIFO storage; contents need no reset since occupancy gates the output.
    always_ff @(posedge HCLK) begin
        if (push) begin
            mem[wr_ptr] <= HRDATA;
        end
    end

endmodule

// File: tb/tb_cnn_img_fetch.sv
// Testbench for cnn_img_fetch: behavioural AHB-Lite slave, table of fetch
// scenarios, scoreboard queue of expected words, plus hand-written reset
// sequences.
module tb_cnn_img_fetch;
    localparam int FIFO_DEPTH = 4;
    localparam int W_CNT      = 16;

    logic             HCLK;
    logic             HRESET;
    logic             i_start;
    logic [31:0]      i_base_addr;
    logic [W_CNT-1:0] i_word_cnt;
    logic [31:0]      HADDR;
    logic [1:0]       HTRANS;
    logic [2:0]       HBURST;
    logic [2:0]       HSIZE;
    logic             HWRITE;
    logic [31:0]      HWDATA;
    logic             HREADY;
    logic [1:0]       HRESP;
    logic [31:0]      HRDATA;
    logic             o_pix_valid;
    logic [31:0]      o_pix_data;
    logic             i_pix_ready;
    logic             o_busy;
    logic             o_done;
    logic             o_err;

    cnn_img_fetch #(.FIFO_DEPTH(FIFO_DEPTH), .W_CNT(W_CNT)) dut (
        .HCLK(HCLK), .HRESET(HRESET), .i_start(i_start),
        .i_base_addr(i_base_addr), .i_word_cnt(i_word_cnt),
        .HADDR(HADDR), .HTRANS(HTRANS), .HBURST(HBURST), .HSIZE(HSIZE),
        .HWRITE(HWRITE), .HWDATA(HWDATA), .HREADY(HREADY), .HRESP(HRESP),
        .HRDATA(HRDATA), .o_pix_valid(o_pix_valid), .o_pix_data(o_pix_data),
        .i_pix_ready(i_pix_ready), .o_busy(o_busy), .o_done(o_done), .o_err(o_err)
    );

    initial HCLK = 1'b0;
    always #5 HCLK = ~HCLK;

    typedef struct {
        logic [31:0]      base;
        logic [W_CNT-1:0] cnt;
        int               stall;      // cycles with i_pix_ready held low
        int               wait_word;  // word index that gets wait states (-1 none)
        int               wait_n;
        int               err_word;   // word index answered with ERROR (-1 none)
        bit               rnd_ready;
        bit               mid_start;  // pulse i_start while busy
        bit               b2b;        // expect requests on consecutive cycles
        int               exp_words;
        int               exp_acc;
        bit               exp_err;
    } vec_t;

    vec_t        vecs [7];
    logic [31:0] exp_q [$];
    int          n_checks = 0;
    int          n_fail   = 0;

    // slave and run tracking
    bit          sl_active;
    logic [31:0] sl_addr;
    int          sl_idx, sl_wait, sl_estage;
    logic [31:0] base_al;
    int          acc, pops, done_cnt, done_cyc, first_acc_cyc, last_acc_cyc, first_vld_cyc;
    bit          err_seen, prev_hold;
    logic [1:0]  prev_htrans;
    logic [31:0] prev_haddr;

    function automatic logic [31:0] memf(input logic [31:0] a);
        return a ^ 32'hA5A5_5A5A;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic clear_tracking();
        acc = 0; pops = 0; done_cnt = 0; done_cyc = -1;
        first_acc_cyc = -1; last_acc_cyc = -1; first_vld_cyc = -1;
        err_seen = 0; prev_hold = 0; sl_active = 0; sl_wait = 0; sl_estage = 0; sl_idx = -1;
        exp_q.delete();
    endtask

    // One bus cycle, called at the negedge: drive slave response and sink,
    // observe the DUT, then account for what the next posedge completes.
    task automatic bus_cycle(input int cyc, input vec_t v);
        bit is_err;
        HRDATA = 32'h0;
        HRESP  = 2'b00;
        HREADY = 1'b1;
        is_err = sl_active && (sl_idx == v.err_word);
        if (sl_active) begin
            if (is_err) begin
                HRESP  = 2'b01;
                HREADY = (sl_estage != 0);
            end else if (sl_wait > 0) begin
                HREADY = 1'b0;
            end else begin
                HRDATA = memf(sl_addr);
            end
        end
        if (cyc < v.stall) i_pix_ready = 1'b0;
        else if (v.rnd_ready) i_pix_ready = 1'($urandom_range(0, 1));
        else i_pix_ready = 1'b1;

        if (prev_hold) begin
            check("hold_htrans", 32'(HTRANS), 32'(prev_htrans));
            check("hold_haddr", HADDR, prev_haddr);
        end
        if (err_seen) check("no_nonseq_after_err", 32'(HTRANS), 32'h0);
        if (v.stall > 0 && cyc == v.stall - 1) begin
            check("stall_nonseq_cnt", 32'(acc), 32'(FIFO_DEPTH));
            check("stall_htrans_idle", 32'(HTRANS), 32'h0);
        end
        if (cyc == 1) begin
            check("fixed_ctrl", {HWRITE, HBURST, HSIZE, 25'h0}, {1'b0, 3'b000, 3'b010, 25'h0});
            check("fixed_hwdata", HWDATA, 32'h0);
            check("busy_cycle1", 32'(o_busy), 32'(v.cnt != '0));
        end
        if (o_pix_valid && first_vld_cyc < 0) first_vld_cyc = cyc;
        if (o_pix_valid && i_pix_ready) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL extra_word: got %h expected no word", o_pix_data);
            end else begin
                check("pix_data", o_pix_data, exp_q.pop_front());
            end
            pops++;
        end
        if (o_done) begin
            done_cnt++;
            if (done_cyc < 0) done_cyc = cyc;
        end

        prev_hold   = !HREADY && !is_err;
        prev_htrans = HTRANS;
        prev_haddr  = HADDR;
        if (is_err && !HREADY) err_seen = 1;
        if (HREADY) begin
            sl_active = 0;
            if (HTRANS == 2'b10) begin
                check("haddr", HADDR, base_al + 32'(acc) * 32'd4);
                if (first_acc_cyc < 0) first_acc_cyc = cyc;
                last_acc_cyc = cyc;
                sl_active = 1;
                sl_addr   = HADDR;
                sl_idx    = acc;
                sl_wait   = (acc == v.wait_word) ? v.wait_n : 0;
                sl_estage = 0;
                acc++;
            end
        end else begin
            if (is_err) sl_estage = 1;
            else sl_wait--;
        end
    endtask

    task automatic run_case(input int id, input vec_t v);
        int cyc;
        bit fin;
        clear_tracking();
        base_al = {v.base[31:2], 2'b00};
        for (int i = 0; i < v.exp_words; i++) exp_q.push_back(memf(base_al + 32'(i) * 32'd4));
        @(negedge HCLK);
        i_start     = 1'b1;
        i_base_addr = v.base;
        i_word_cnt  = v.cnt;
        bus_cycle(0, v);
        fin = 0;
        cyc = 1;
        while (!fin && cyc < 400) begin
            @(negedge HCLK);
            i_start = v.mid_start && (cyc == 4);
            if (i_start) begin
                i_base_addr = 32'h0000_9000;
                i_word_cnt  = 16'd2;
            end
            bus_cycle(cyc, v);
            if (done_cnt > 0 && cyc > done_cyc && !o_pix_valid) fin = 1;
            cyc++;
        end
        if (!fin) begin
            n_checks++;
            n_fail++;
            $display("FAIL case%0d_timeout: got no completion after %0d cycles, required o_done and drained FIFO", id, cyc);
        end
        check("words_delivered", 32'(pops), 32'(v.exp_words));
        check("queue_empty", 32'(exp_q.size()), 32'h0);
        check("nonseq_count", 32'(acc), 32'(v.exp_acc));
        check("done_pulses", 32'(done_cnt), 32'h1);
        check("err_flag", 32'(o_err), 32'(v.exp_err));
        check("busy_end", 32'(o_busy), 32'h0);
        if (v.cnt == '0) begin
            check("zero_done_cycle", 32'(done_cyc), 32'h1);
        end else begin
            check("first_nonseq_cycle", 32'(first_acc_cyc), 32'h1);
            check("first_valid_cycle", 32'(first_vld_cyc), 32'h3);
        end
        if (v.b2b) check("b2b_span", 32'(last_acc_cyc - first_acc_cyc), 32'(v.exp_acc - 1));
    endtask

    task automatic check_reset_outputs();
        check("rst_htrans", 32'(HTRANS), 32'h0);
        check("rst_haddr", HADDR, 32'h0);
        check("rst_valid", 32'(o_pix_valid), 32'h0);
        check("rst_data", o_pix_data, 32'h0);
        check("rst_busy", 32'(o_busy), 32'h0);
        check("rst_done", 32'(o_done), 32'h0);
        check("rst_err", 32'(o_err), 32'h0);
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation still running at %0t", $time);
        $fatal(1, "watchdog expired");
    end

    initial begin
        vec_t vr;
        //          base          cnt    stall wword wn ew  rnd mid b2b words acc err
        vecs[0] = '{32'h0000_1000, 16'd8, 0,  -1,  0, -1, 1'b0, 1'b0, 1'b1, 8, 8, 1'b0};
        vecs[1] = '{32'h0000_1000, 16'd8, 12, -1,  0, -1, 1'b0, 1'b0, 1'b0, 8, 8, 1'b0};
        vecs[2] = '{32'h0000_1000, 16'd8, 0,   2,  2, -1, 1'b0, 1'b0, 1'b0, 8, 8, 1'b0};
        vecs[3] = '{32'h0000_1000, 16'd8, 0,  -1,  0,  4, 1'b0, 1'b0, 1'b0, 4, 5, 1'b1};
        vecs[4] = '{32'h0000_1000, 16'd0, 0,  -1,  0, -1, 1'b0, 1'b0, 1'b0, 0, 0, 1'b0};
        vecs[5] = '{32'hFFFF_FFF8, 16'd3, 0,  -1,  0, -1, 1'b0, 1'b0, 1'b1, 3, 3, 1'b0};
        vecs[6] = '{32'h0000_2002, 16'd5, 0,  -1,  0, -1, 1'b1, 1'b1, 1'b0, 5, 5, 1'b0};

        HRESET = 1'b1; i_start = 1'b0; i_base_addr = 32'h0; i_word_cnt = '0;
        HREADY = 1'b1; HRESP = 2'b00; HRDATA = 32'h0; i_pix_ready = 1'b0;
        clear_tracking();
        repeat (3) @(negedge HCLK);
        check_reset_outputs();
        HRESET = 1'b0;
        @(negedge HCLK);

        for (int i = 0; i < 7; i++) run_case(i, vecs[i]);

        // reset in the middle of a fetch
        vr = '{32'h0000_4000, 16'd8, 0, -1, 0, -1, 1'b0, 1'b0, 1'b0, 8, 8, 1'b0};
        clear_tracking();
        base_al = 32'h0000_4000;
        for (int i = 0; i < 8; i++) exp_q.push_back(memf(base_al + 32'(i) * 32'd4));
        @(negedge HCLK);
        i_start = 1'b1; i_base_addr = vr.base; i_word_cnt = vr.cnt;
        bus_cycle(0, vr);
        for (int c = 1; c <= 4; c++) begin
            @(negedge HCLK);
            i_start = 1'b0;
            bus_cycle(c, vr);
        end
        @(negedge HCLK);
        HRESET = 1'b1;
        bus_cycle(5, vr);
        @(negedge HCLK);
        HRESET = 1'b0; HREADY = 1'b1; HRESP = 2'b00; HRDATA = 32'h0; i_pix_ready = 1'b1;
        check_reset_outputs();
        clear_tracking();
        for (int c = 0; c < 6; c++) begin
            @(negedge HCLK);
            check("post_rst_htrans", 32'(HTRANS), 32'h0);
            check("post_rst_valid", 32'(o_pix_valid), 32'h0);
        end

        // normal fetch again after the abort
        run_case(7, vecs[0]);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
